// File: rtl/uart_rx_deframer_pkg.sv
// Shared types and constants for the UART byte-to-word deframer.
// States, abort codes and the FIFO entry layout.
package uart_rx_deframer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LEN,
    ST_PAYLOAD,
    ST_CHECK
  } state_t;

  typedef logic [2:0] err_code_t;

  localparam err_code_t ERR_NONE     = 3'd0;
  localparam err_code_t ERR_PARITY   = 3'd1;
  localparam err_code_t ERR_CHK      = 3'd2;
  localparam err_code_t ERR_TIMEOUT  = 3'd3;
  localparam err_code_t ERR_OVERFLOW = 3'd4;
  localparam err_code_t ERR_ZLEN     = 3'd5;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  typedef struct packed {
    logic        last;
    logic [31:0] word;
  } fifo_word_t;

endpackage

// File: rtl/uart_rx_deframer_fifo.sv
// Synchronous word FIFO (word + Last flag) with count-based flags.
// Head is forced to zero while empty so outputs are clean out of reset.
module word_fifo
  import uart_rx_deframer_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       i_Clock,
  input  logic       i_Rst_n,
  input  logic       wr_en,
  input  fifo_word_t wr_data,
  input  logic       rd_en,
  output fifo_word_t rd_data,
  output logic       empty,
  output logic       full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  fifo_word_t mem [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_wr;
  logic          do_rd;

  assign empty = (count == '0);
  assign full  = (count == DEPTH_C);
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge i_Clock) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_deframer.sv
// Hunts for SYNC, parses length-prefixed frames, packs payload into
// little-endian words and queues them for the loader.
module uart_rx_deframer
  import uart_rx_deframer_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF,
  parameter int         FIFO_DEPTH   = 8,
  parameter int         TIMEOUT_CLKS = 1740
) (
  input  logic        i_Clock,
  input  logic        i_Rst_n,
  input  logic        i_Rx_DV,
  input  logic [7:0]  i_Rx_Byte,
  input  logic        i_Rx_Error,
  output logic [31:0] o_Word,
  output logic        o_Word_Last,
  output logic        o_Word_Valid,
  input  logic        i_Word_Ready,
  output logic        o_Frame_Done,
  output logic        o_Frame_Err,
  output logic [2:0]  o_Err_Code,
  output logic        o_Active
);

  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);

  state_t      state_q, state_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  chk_q, chk_d;
  logic [1:0]  lane_q, lane_d;
  logic [7:0]  wcnt_q, wcnt_d;
  logic [23:0] word_q, word_d;
  logic [TW-1:0] tmo_q, tmo_d;
  err_code_t   code_q, code_d;
  logic        done_q, done_d;
  logic        err_q;

  logic       abort;
  err_code_t  abort_code;
  logic       push;
  logic       push_last;
  logic       ovf;
  logic       pop;
  logic       empty;
  logic       full;
  fifo_word_t head;
  fifo_word_t wdata;

  assign pop = !empty && i_Word_Ready;
  assign ovf = push && full && !pop;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    chk_d      = chk_q;
    lane_d     = lane_q;
    wcnt_d     = wcnt_q;
    word_d     = word_q;
    code_d     = code_q;
    done_d     = 1'b0;
    abort      = 1'b0;
    abort_code = ERR_NONE;
    push       = 1'b0;
    push_last  = 1'b0;
    tmo_d      = (state_q == ST_IDLE || i_Rx_DV) ? '0 : tmo_q + TW'(1);

    unique case (state_q)
      ST_IDLE: begin
        if (i_Rx_DV && !i_Rx_Error && i_Rx_Byte == SYNC_BYTE)
          state_d = ST_LEN;
      end
      ST_LEN: begin
        if (i_Rx_DV) begin
          unique case (1'b1)
            i_Rx_Error: begin
              abort      = 1'b1;
              abort_code = ERR_PARITY;
            end
            (i_Rx_Byte == 8'd0): begin
              abort      = 1'b1;
              abort_code = ERR_ZLEN;
            end
            default: begin
              len_d   = i_Rx_Byte;
              chk_d   = i_Rx_Byte;
              lane_d  = 2'd0;
              wcnt_d  = 8'd0;
              state_d = ST_PAYLOAD;
            end
          endcase
        end
      end
      ST_PAYLOAD: begin
        if (i_Rx_DV && i_Rx_Error) begin
          abort      = 1'b1;
          abort_code = ERR_PARITY;
        end else if (i_Rx_DV) begin
          chk_d  = chk_q ^ i_Rx_Byte;
          lane_d = lane_q + 2'd1;
          unique case (lane_q)
            2'd0: word_d[7:0]   = i_Rx_Byte;
            2'd1: word_d[15:8]  = i_Rx_Byte;
            2'd2: word_d[23:16] = i_Rx_Byte;
            2'd3: begin
              push      = 1'b1;
              push_last = (wcnt_q == len_q - 8'd1);
              wcnt_d    = wcnt_q + 8'd1;
              if (ovf) begin
                abort      = 1'b1;
                abort_code = ERR_OVERFLOW;
              end else if (push_last) begin
                state_d = ST_CHECK;
              end
            end
          endcase
        end
      end
      ST_CHECK: begin
        if (i_Rx_DV) begin
          unique case (1'b1)
            i_Rx_Error: begin
              abort      = 1'b1;
              abort_code = ERR_PARITY;
            end
            (i_Rx_Byte == chk_q): begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end
            default: begin
              abort      = 1'b1;
              abort_code = ERR_CHK;
            end
          endcase
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Silence inside a frame: terminal count fires on the next quiet edge
    if (state_q != ST_IDLE && !i_Rx_DV && tmo_q == TMO_LAST) begin
      abort      = 1'b1;
      abort_code = ERR_TIMEOUT;
    end

    if (abort) begin
      state_d = ST_IDLE;
      code_d  = abort_code;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      chk_q   <= '0;
      lane_q  <= '0;
      wcnt_q  <= '0;
      word_q  <= '0;
      tmo_q   <= '0;
      code_q  <= ERR_NONE;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      chk_q   <= chk_d;
      lane_q  <= lane_d;
      wcnt_q  <= wcnt_d;
      word_q  <= word_d;
      tmo_q   <= tmo_d;
      code_q  <= code_d;
      done_q  <= done_d;
      err_q   <= abort;
    end
  end

  assign wdata.last = push_last;
  assign wdata.word = {i_Rx_Byte, word_q};

  word_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_Clock (i_Clock),
    .i_Rst_n (i_Rst_n),
    .wr_en   (push && !ovf),
    .wr_data (wdata),
    .rd_en   (i_Word_Ready),
    .rd_data (head),
    .empty   (empty),
    .full    (full)
  );

  assign o_Word       = head.word;
  assign o_Word_Last  = head.last;
  assign o_Word_Valid = !empty;
  assign o_Frame_Done = done_q;
  assign o_Frame_Err  = err_q;
  assign o_Err_Code   = code_q;
  assign o_Active     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed and randomized bench for uart_rx_deframer against a
// frame-level reference model.
module tb_uart_rx_deframer;

  localparam int TMO   = 60;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dv = 1'b0;
  logic        perr = 1'b0;
  logic [7:0]  rxb = 8'h00;
  logic        ready_dir = 1'b0;
  logic        rand_ready = 1'b0;
  logic        rr = 1'b0;
  logic        ready;
  logic [31:0] o_Word;
  logic        o_Word_Last;
  logic        o_Word_Valid;
  logic        o_Frame_Done;
  logic        o_Frame_Err;
  logic [2:0]  o_Err_Code;
  logic        o_Active;

  int checks = 0;
  int errors = 0;
  int n_done = 0;
  int n_err = 0;
  logic [32:0] rec_q[$];

  assign ready = rand_ready ? rr : ready_dir;

  uart_rx_deframer #(
    .SYNC_BYTE    (8'hA5),
    .FIFO_DEPTH   (DEPTH),
    .TIMEOUT_CLKS (TMO)
  ) dut (
    .i_Clock      (clk),
    .i_Rst_n      (rst_n),
    .i_Rx_DV      (dv),
    .i_Rx_Byte    (rxb),
    .i_Rx_Error   (perr),
    .o_Word       (o_Word),
    .o_Word_Last  (o_Word_Last),
    .o_Word_Valid (o_Word_Valid),
    .i_Word_Ready (ready),
    .o_Frame_Done (o_Frame_Done),
    .o_Frame_Err  (o_Frame_Err),
    .o_Err_Code   (o_Err_Code),
    .o_Active     (o_Active)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1 rr = 1'($urandom_range(0, 1));
  end

  // Pops and pulses observed mid-cycle
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_Word_Valid && ready) rec_q.push_back({o_Word_Last, o_Word});
      if (o_Frame_Done) n_done++;
      if (o_Frame_Err) n_err++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic pe);
    @(posedge clk); #1;
    dv = 1'b1; rxb = b; perr = pe;
    @(posedge clk); #1;
    dv = 1'b0; perr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_q(input logic [7:0] q[$]);
    foreach (q[i]) send(q[i], 1'b0);
  endtask

  // Reference: pack payload little-endian, Last on final word
  task automatic model_words(input logic [7:0] len, input logic [7:0] p[$],
                             input int nw, output logic [32:0] w[$]);
    w = {};
    for (int i = 0; i < nw; i++)
      w.push_back({(i == int'(len) - 1),
                   p[4*i+3], p[4*i+2], p[4*i+1], p[4*i]});
  endtask

  task automatic cmp_words(input string tag, input logic [32:0] exp[$]);
    check({tag, "_nwords"}, 64'(rec_q.size()), 64'(exp.size()));
    foreach (exp[i])
      if (i < rec_q.size()) check({tag, "_word"}, 64'(rec_q[i]), 64'(exp[i]));
  endtask

  initial begin
    logic [7:0]  fr[$];
    logic [7:0]  pl[$];
    logic [32:0] ew[$];
    logic [7:0]  len, chk;
    int d0, e0, n;
    bit ok, bad;

    #2;
    check("rst_outputs",
          {o_Word, o_Word_Last, o_Word_Valid, o_Frame_Done, o_Frame_Err,
           o_Err_Code, o_Active}, 64'd0);
    idle(3);
    rst_n = 1'b1;
    idle(2);

    // Good frame, ready low to observe write latency
    d0 = n_done; e0 = n_err; rec_q = {};
    send(8'hA5, 1'b0);
    check("active_after_sync", o_Active, 1);
    send_q('{8'h01, 8'h78, 8'h56, 8'h34});
    check("valid_before_word", o_Word_Valid, 0);
    send(8'h12, 1'b0);
    check("word_latency", {o_Word_Valid, o_Word_Last, o_Word},
          {1'b1, 1'b1, 32'h12345678});
    send(8'h09, 1'b0);
    check("done_pulse", o_Frame_Done, 1);
    ready_dir = 1'b1;
    idle(5);
    cmp_words("good", '{{1'b1, 32'h12345678}});
    check("good_done_cnt", n_done - d0, 1);
    check("good_err_cnt", n_err - e0, 0);
    check("good_code", o_Err_Code, 0);
    check("good_idle", o_Active, 0);

    // Hunt with bad checksum
    e0 = n_err; rec_q = {};
    send_q('{8'h00, 8'hFF});
    check("hunt_idle", o_Active, 0);
    send_q('{8'hA5, 8'h01, 8'h78, 8'h56, 8'h34, 8'h12});
    send(8'h08, 1'b0);
    check("chk_err_pulse", o_Frame_Err, 1);
    idle(4);
    cmp_words("hunt", '{{1'b1, 32'h12345678}});
    check("hunt_err_cnt", n_err - e0, 1);
    check("hunt_code", o_Err_Code, 2);

    // Zero length
    e0 = n_err; rec_q = {};
    send_q('{8'hA5, 8'h00});
    idle(4);
    check("zlen_err_cnt", n_err - e0, 1);
    check("zlen_code", o_Err_Code, 5);

    // Parity error on third payload byte
    e0 = n_err; rec_q = {};
    send_q('{8'hA5, 8'h02, 8'h11, 8'h22});
    send(8'h33, 1'b1);
    send(8'h44, 1'b0);
    idle(4);
    check("par_nwords", rec_q.size(), 0);
    check("par_err_cnt", n_err - e0, 1);
    check("par_code", o_Err_Code, 1);

    // Timeout measured from the last sampled byte
    e0 = n_err; rec_q = {};
    send_q('{8'hA5, 8'h02, 8'hDD, 8'hCC, 8'hBB, 8'hAA});
    n = 0;
    bad = 1'b1;
    for (int i = 0; i < TMO + 20; i++) begin
      @(posedge clk); #1;
      n++;
      if (o_Frame_Err) begin bad = 1'b0; break; end
    end
    check("tmo_seen", bad, 0);
    check("tmo_clks", n, TMO);
    check("tmo_code", o_Err_Code, 3);
    check("tmo_idle", o_Active, 0);
    idle(3);
    cmp_words("tmo", '{{1'b0, 32'hAABBCCDD}});

    // Overflow: nine words into eight slots with consumer stalled
    ready_dir = 1'b0; e0 = n_err; rec_q = {};
    pl = {};
    for (int i = 0; i < 36; i++) pl.push_back(8'($urandom));
    send_q('{8'hA5, 8'h09});
    send_q(pl);
    idle(2);
    check("ovf_err_cnt", n_err - e0, 1);
    check("ovf_code", o_Err_Code, 4);
    ready_dir = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      ok &= o_Word_Valid;
    end
    @(negedge clk);
    check("ovf_drain_8", {ok, o_Word_Valid}, 2'b10);
    idle(1);
    model_words(8'd9, pl, 8, ew);
    cmp_words("ovf", ew);

    // Reset mid-frame with three words queued
    ready_dir = 1'b0; rec_q = {};
    pl = {};
    for (int i = 0; i < 12; i++) pl.push_back(8'($urandom));
    send_q('{8'hA5, 8'h05});
    send_q(pl);
    check("mid_valid", {o_Word_Valid, o_Active}, 2'b11);
    rst_n = 1'b0;
    #1;
    check("mid_rst_outputs",
          {o_Word, o_Word_Last, o_Word_Valid, o_Frame_Done, o_Frame_Err,
           o_Err_Code, o_Active}, 64'd0);
    idle(2);
    rst_n = 1'b1;
    idle(2);
    check("post_rst_empty", {o_Word_Valid, o_Active}, 0);
    ready_dir = 1'b1;

    // Randomized frames against the reference model
    for (int f = 0; f < 25; f++) begin
      d0 = n_done; e0 = n_err; rec_q = {};
      len = 8'($urandom_range(1, 8));
      pl = {};
      for (int i = 0; i < 4 * int'(len); i++) pl.push_back(8'($urandom));
      chk = len;
      foreach (pl[i]) chk ^= pl[i];
      bad = ($urandom_range(0, 3) == 0);
      fr = {};
      for (int j = $urandom_range(0, 2); j > 0; j--)
        fr.push_back(8'($urandom_range(0, 8'hA4)));
      fr.push_back(8'hA5);
      fr.push_back(len);
      foreach (pl[i]) fr.push_back(pl[i]);
      fr.push_back(bad ? chk ^ 8'($urandom_range(1, 255)) : chk);
      model_words(len, pl, int'(len), ew);
      rand_ready = 1'b1;
      foreach (fr[i]) begin
        send(fr[i], 1'b0);
        if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      end
      rand_ready = 1'b0;
      idle(DEPTH + 4);
      cmp_words("rnd", ew);
      check("rnd_done_cnt", n_done - d0, bad ? 0 : 1);
      check("rnd_err_cnt", n_err - e0, bad ? 1 : 0);
      if (bad) check("rnd_code", o_Err_Code, 2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
